pipelined_riscv_core: RTL and testbench

- Five-stage (IF/ID/EX/MEM/WB) in-order RV32 integer subset core with internal instruction memory, data memory and register file.
- Load-use hazard detection, EX-stage forwarding, and branch resolution in ID with one-cycle flush.
- Top of the CPU hierarchy; only clock, reset and start are external.

---
 rtl/pipelined_riscv_core_pkg.sv | 100 ++++++++++
 rtl/pipelined_riscv_core_control.sv | 62 ++++++
 rtl/pipelined_riscv_core_hazard_forward_unit.sv | 48 ++++
 rtl/pipelined_riscv_core_mem.sv | 27 ++
 rtl/pipelined_riscv_core_pc.sv | 29 ++
 rtl/pipelined_riscv_core_pipe_reg.sv | 39 +++
 rtl/pipelined_riscv_core_regfile.sv | 40 ++++
 rtl/pipelined_riscv_core.sv | 153 +++++++++++++++
 tb/tb_pipelined_riscv_core.sv | 176 +++++++++++++++++
 9 files changed

// File: rtl/pipelined_riscv_core_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pipelined_riscv_core_pkg : encodings, pipeline-register layouts and ALU
// Revision : 1.0
// ----------------------------------------------------------------------------
package pipelined_riscv_core_pkg;

   localparam logic [6:0] OPC_R      = 7'b0110011;
   localparam logic [6:0] OPC_I      = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   localparam logic [2:0] F3_ADD_SUB = 3'b000;
   localparam logic [2:0] F3_SLL     = 3'b001;
   localparam logic [2:0] F3_LW_SW   = 3'b010;
   localparam logic [2:0] F3_XOR     = 3'b100;
   localparam logic [2:0] F3_SR      = 3'b101;
   localparam logic [2:0] F3_AND     = 3'b111;
   localparam logic [2:0] F3_BEQ     = 3'b000;

   localparam logic [6:0] F7_BASE    = 7'b0000000;
   localparam logic [6:0] F7_ALT     = 7'b0100000;
   localparam logic [6:0] F7_MULDIV  = 7'b0000001;

   typedef enum logic [2:0] {
      ALU_ADD = 3'd0,
      ALU_SUB = 3'd1,
      ALU_AND = 3'd2,
      ALU_XOR = 3'd3,
      ALU_SLL = 3'd4,
      ALU_SRA = 3'd5,
      ALU_MUL = 3'd6
   } alu_op_e;

   typedef enum logic [1:0] {
      FWD_REG   = 2'b00,
      FWD_EXMEM = 2'b10,
      FWD_MEMWB = 2'b01
   } fwd_sel_e;

   // All-zero value of every struct below is a NOP bubble
   typedef struct packed {
      logic    reg_write;
      logic    mem_read;
      logic    mem_write;
      logic    mem_to_reg;
      logic    alu_src;
      alu_op_e alu_op;
   } ctrl_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } if_id_t;

   typedef struct packed {
      ctrl_t       ctrl;
      logic [31:0] rs1_data;
      logic [31:0] rs2_data;
      logic [31:0] imm;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
   } id_ex_t;

   typedef struct packed {
      logic        reg_write;
      logic        mem_write;
      logic        mem_to_reg;
      logic [31:0] alu_result;
      logic [31:0] store_data;
      logic [4:0]  rd;
   } ex_mem_t;

   typedef struct packed {
      logic        reg_write;
      logic        mem_to_reg;
      logic [31:0] alu_result;
      logic [31:0] mem_data;
      logic [4:0]  rd;
   } mem_wb_t;

   function automatic logic [31:0] alu(input alu_op_e op, input logic [31:0] a,
                                       input logic [31:0] b);
      logic [31:0] res;
      case (op)
         ALU_SUB: res = a - b;
         ALU_AND: res = a & b;
         ALU_XOR: res = a ^ b;
         ALU_SLL: res = a << b[4:0];
         ALU_SRA: res = $signed(a) >>> b[4:0];
         ALU_MUL: res = a * b;
         default: res = a + b;
      endcase
      return res;
   endfunction

endpackage
`default_nettype wire

// File: rtl/pipelined_riscv_core_control.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pipelined_riscv_core_control : main decoder; unknown encodings decode as NOP
// Revision : 1.0
// ----------------------------------------------------------------------------
module pipelined_riscv_core_control
   import pipelined_riscv_core_pkg::*;
(
   input  logic [6:0] opcode_i,
   input  logic [2:0] funct3_i,
   input  logic [6:0] funct7_i,
   output ctrl_t      ctrl_o,
   output logic       Branch_o
);

   always_comb begin
      ctrl_o   = '0;
      Branch_o = 1'b0;
      case (opcode_i)
         OPC_R: begin
            ctrl_o.reg_write = 1'b1;
            case ({funct7_i, funct3_i})
               {F7_BASE,   F3_ADD_SUB}: ctrl_o.alu_op = ALU_ADD;
               {F7_ALT,    F3_ADD_SUB}: ctrl_o.alu_op = ALU_SUB;
               {F7_MULDIV, F3_ADD_SUB}: ctrl_o.alu_op = ALU_MUL;
               {F7_BASE,   F3_SLL}:     ctrl_o.alu_op = ALU_SLL;
               {F7_BASE,   F3_XOR}:     ctrl_o.alu_op = ALU_XOR;
               {F7_BASE,   F3_AND}:     ctrl_o.alu_op = ALU_AND;
               default:                 ctrl_o.reg_write = 1'b0;
            endcase
         end
         OPC_I: begin
            if (funct3_i == F3_ADD_SUB) begin
               ctrl_o.reg_write = 1'b1;
               ctrl_o.alu_src   = 1'b1;
            end else if ((funct3_i == F3_SR) && (funct7_i == F7_ALT)) begin
               ctrl_o.reg_write = 1'b1;
               ctrl_o.alu_src   = 1'b1;
               ctrl_o.alu_op    = ALU_SRA;
            end
         end
         OPC_LOAD: begin
            if (funct3_i == F3_LW_SW) begin
               ctrl_o.reg_write  = 1'b1;
               ctrl_o.mem_read   = 1'b1;
               ctrl_o.mem_to_reg = 1'b1;
               ctrl_o.alu_src    = 1'b1;
            end
         end
         OPC_STORE: begin
            if (funct3_i == F3_LW_SW) begin
               ctrl_o.mem_write = 1'b1;
               ctrl_o.alu_src   = 1'b1;
            end
         end
         OPC_BRANCH: Branch_o = (funct3_i == F3_BEQ);
         default: ;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/pipelined_riscv_core_hazard_forward_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pipelined_riscv_core_hazard_forward_unit : load-use stall and EX forwarding
// Revision : 1.0
// ----------------------------------------------------------------------------
module pipelined_riscv_core_hazard_forward_unit
   import pipelined_riscv_core_pkg::*;
(
   input  logic [4:0] id_rs1_i,
   input  logic [4:0] id_rs2_i,
   input  logic       ex_mem_read_i,
   input  logic [4:0] ex_rd_i,
   input  logic [4:0] ex_rs1_i,
   input  logic [4:0] ex_rs2_i,
   input  logic       mem_reg_write_i,
   input  logic [4:0] mem_rd_i,
   input  logic       wb_reg_write_i,
   input  logic [4:0] wb_rd_i,
   output logic       Stall_o,
   output fwd_sel_e   fwd_a_o,
   output fwd_sel_e   fwd_b_o
);

   logic mem_valid;
   logic wb_valid;

   always_comb begin
      mem_valid = mem_reg_write_i && (mem_rd_i != 5'd0);
      wb_valid  = wb_reg_write_i && (wb_rd_i != 5'd0);
      Stall_o   = ex_mem_read_i && (ex_rd_i != 5'd0) &&
                  ((ex_rd_i == id_rs1_i) || (ex_rd_i == id_rs2_i));

      // The younger producer (EX/MEM) wins over MEM/WB
      fwd_a_o = FWD_REG;
      if (mem_valid && (mem_rd_i == ex_rs1_i))
         fwd_a_o = FWD_EXMEM;
      else if (wb_valid && (wb_rd_i == ex_rs1_i))
         fwd_a_o = FWD_MEMWB;

      fwd_b_o = FWD_REG;
      if (mem_valid && (mem_rd_i == ex_rs2_i))
         fwd_b_o = FWD_EXMEM;
      else if (wb_valid && (wb_rd_i == ex_rs2_i))
         fwd_b_o = FWD_MEMWB;
   end

endmodule
`default_nettype wire

// File: rtl/pipelined_riscv_core_mem.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pipelined_riscv_core_mem : word memory, combinational read, clocked write.
// Contents are not reset.
// Revision : 1.0
// ----------------------------------------------------------------------------
module pipelined_riscv_core_mem #(
   parameter int WORDS = 32
) (
   input  logic                     clk_i,
   input  logic                     we_i,
   input  logic [$clog2(WORDS)-1:0] addr_i,
   input  logic [31:0]              wdata_i,
   output logic [31:0]              rdata_o
);

   logic [31:0] memory [WORDS];

   always_ff @(posedge clk_i) begin
      if (we_i)
         memory[addr_i] <= wdata_i;
   end

   assign rdata_o = memory[addr_i];

endmodule
`default_nettype wire

// File: rtl/pipelined_riscv_core_pc.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pipelined_riscv_core_pc : program counter with load enable
// Revision : 1.0
// ----------------------------------------------------------------------------
module pipelined_riscv_core_pc (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        en_i,
   input  logic [31:0] pc_i,
   output logic [31:0] pc_o
);

   logic [31:0] pc_q;
   logic [31:0] pc_d;

   always_comb pc_d = en_i ? pc_i : pc_q;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i)
         pc_q <= '0;
      else
         pc_q <= pc_d;
   end

   assign pc_o = pc_q;

endmodule
`default_nettype wire

// File: rtl/pipelined_riscv_core_pipe_reg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pipelined_riscv_core_pipe_reg : pipeline register; clear has priority over
// hold, and a cleared value is a NOP bubble
// Revision : 1.0
// ----------------------------------------------------------------------------
module pipelined_riscv_core_pipe_reg #(
   parameter int WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             en_i,
   input  logic             clr_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] data_q;
   logic [WIDTH-1:0] data_d;

   always_comb begin
      data_d = data_q;
      if (clr_i)
         data_d = '0;
      else if (en_i)
         data_d = d_i;
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i)
         data_q <= '0;
      else
         data_q <= data_d;
   end

   assign q_o = data_q;

endmodule
`default_nettype wire

// File: rtl/pipelined_riscv_core_regfile.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pipelined_riscv_core_regfile : 32x32 register file, x0 hardwired to zero,
// write-before-read bypass. Contents are not reset.
// Revision : 1.0
// ----------------------------------------------------------------------------
module pipelined_riscv_core_regfile (
   input  logic        clk_i,
   input  logic [4:0]  rs1_i,
   input  logic [4:0]  rs2_i,
   output logic [31:0] rs1_data_o,
   output logic [31:0] rs2_data_o,
   input  logic        we_i,
   input  logic [4:0]  rd_i,
   input  logic [31:0] wd_i
);

   logic [31:0] register [32];

   always_ff @(posedge clk_i) begin
      if (we_i && (rd_i != 5'd0))
         register[rd_i] <= wd_i;
   end

   always_comb begin
      rs1_data_o = register[rs1_i];
      if (rs1_i == 5'd0)
         rs1_data_o = '0;
      else if (we_i && (rd_i == rs1_i))
         rs1_data_o = wd_i;

      rs2_data_o = register[rs2_i];
      if (rs2_i == 5'd0)
         rs2_data_o = '0;
      else if (we_i && (rd_i == rs2_i))
         rs2_data_o = wd_i;
   end

endmodule
`default_nettype wire

// File: rtl/pipelined_riscv_core.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pipelined_riscv_core : five-stage in-order RV32 integer-subset core with
// internal instruction/data memories; branches resolve in ID.
// Revision : 1.0
// ----------------------------------------------------------------------------
module pipelined_riscv_core
   import pipelined_riscv_core_pkg::*;
#(
   parameter int IMEM_WORDS = 256,
   parameter int DMEM_WORDS = 32
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic start_i
);

   localparam int IAW = $clog2(IMEM_WORDS);
   localparam int DAW = $clog2(DMEM_WORDS);

   logic [31:0] pc, pc_next, instr_f;
   logic        pc_en, if_id_clr, stall, branch, Flush;
   logic [31:0] rs1_data, rs2_data, id_imm, br_target;
   logic [31:0] op_a, op_b, store_data, dmem_rdata, wb_data;
   ctrl_t       id_ctrl;
   fwd_sel_e    fwd_a, fwd_b;
   if_id_t      if_id_d, if_id_q;
   id_ex_t      id_ex_d, id_ex_q;
   ex_mem_t     ex_mem_d, ex_mem_q;
   mem_wb_t     mem_wb_d, mem_wb_q;

   // ---------------- IF ----------------
   pipelined_riscv_core_pc PC (
      .clk_i(clk_i), .rst_i(rst_i), .en_i(pc_en), .pc_i(pc_next), .pc_o(pc)
   );

   pipelined_riscv_core_mem #(.WORDS(IMEM_WORDS)) Instruction_Memory (
      .clk_i(clk_i), .we_i(1'b0), .addr_i(pc[IAW+1:2]), .wdata_i(32'd0),
      .rdata_o(instr_f)
   );

   // While start_i is low the held PC is not re-issued: IF/ID takes bubbles
   always_comb begin
      pc_en         = Flush || (start_i && !stall);
      pc_next       = Flush ? br_target : pc + 32'd4;
      if_id_clr     = Flush || (!start_i && !stall);
      if_id_d.pc    = pc;
      if_id_d.instr = instr_f;
   end

   pipelined_riscv_core_pipe_reg #(.WIDTH($bits(if_id_t))) IFIDRegisters (
      .clk_i(clk_i), .rst_i(rst_i), .en_i(!stall), .clr_i(if_id_clr),
      .d_i(if_id_d), .q_o(if_id_q)
   );

   // ---------------- ID ----------------
   pipelined_riscv_core_regfile Registers (
      .clk_i(clk_i),
      .rs1_i(if_id_q.instr[19:15]), .rs2_i(if_id_q.instr[24:20]),
      .rs1_data_o(rs1_data), .rs2_data_o(rs2_data),
      .we_i(mem_wb_q.reg_write), .rd_i(mem_wb_q.rd), .wd_i(wb_data)
   );

   pipelined_riscv_core_control Control (
      .opcode_i(if_id_q.instr[6:0]), .funct3_i(if_id_q.instr[14:12]),
      .funct7_i(if_id_q.instr[31:25]), .ctrl_o(id_ctrl), .Branch_o(branch)
   );

   pipelined_riscv_core_hazard_forward_unit HazardDetectionUnit (
      .id_rs1_i(if_id_q.instr[19:15]), .id_rs2_i(if_id_q.instr[24:20]),
      .ex_mem_read_i(id_ex_q.ctrl.mem_read), .ex_rd_i(id_ex_q.rd),
      .ex_rs1_i(id_ex_q.rs1), .ex_rs2_i(id_ex_q.rs2),
      .mem_reg_write_i(ex_mem_q.reg_write), .mem_rd_i(ex_mem_q.rd),
      .wb_reg_write_i(mem_wb_q.reg_write), .wb_rd_i(mem_wb_q.rd),
      .Stall_o(stall), .fwd_a_o(fwd_a), .fwd_b_o(fwd_b)
   );

   // A branch seen during a stall is re-evaluated once the stall clears
   always_comb begin
      id_imm = {{20{if_id_q.instr[31]}}, if_id_q.instr[31:20]};
      if (if_id_q.instr[6:0] == OPC_STORE)
         id_imm = {{20{if_id_q.instr[31]}}, if_id_q.instr[31:25], if_id_q.instr[11:7]};
      br_target = if_id_q.pc + {{19{if_id_q.instr[31]}}, if_id_q.instr[31],
                                if_id_q.instr[7], if_id_q.instr[30:25],
                                if_id_q.instr[11:8], 1'b0};
      Flush = branch && (rs1_data == rs2_data) && !stall;

      id_ex_d.ctrl     = id_ctrl;
      id_ex_d.rs1_data = rs1_data;
      id_ex_d.rs2_data = rs2_data;
      id_ex_d.imm      = id_imm;
      id_ex_d.rs1      = if_id_q.instr[19:15];
      id_ex_d.rs2      = if_id_q.instr[24:20];
      id_ex_d.rd       = if_id_q.instr[11:7];
   end

   pipelined_riscv_core_pipe_reg #(.WIDTH($bits(id_ex_t))) IDEXRegisters (
      .clk_i(clk_i), .rst_i(rst_i), .en_i(1'b1), .clr_i(stall),
      .d_i(id_ex_d), .q_o(id_ex_q)
   );

   // ---------------- EX ----------------
   always_comb begin
      case (fwd_a)
         FWD_EXMEM: op_a = ex_mem_q.alu_result;
         FWD_MEMWB: op_a = wb_data;
         default:   op_a = id_ex_q.rs1_data;
      endcase
      case (fwd_b)
         FWD_EXMEM: store_data = ex_mem_q.alu_result;
         FWD_MEMWB: store_data = wb_data;
         default:   store_data = id_ex_q.rs2_data;
      endcase
      op_b = id_ex_q.ctrl.alu_src ? id_ex_q.imm : store_data;

      ex_mem_d.reg_write  = id_ex_q.ctrl.reg_write;
      ex_mem_d.mem_write  = id_ex_q.ctrl.mem_write;
      ex_mem_d.mem_to_reg = id_ex_q.ctrl.mem_to_reg;
      ex_mem_d.alu_result = alu(id_ex_q.ctrl.alu_op, op_a, op_b);
      ex_mem_d.store_data = store_data;
      ex_mem_d.rd         = id_ex_q.rd;
   end

   pipelined_riscv_core_pipe_reg #(.WIDTH($bits(ex_mem_t))) EXMEMRegisters (
      .clk_i(clk_i), .rst_i(rst_i), .en_i(1'b1), .clr_i(1'b0),
      .d_i(ex_mem_d), .q_o(ex_mem_q)
   );

   // ---------------- MEM ----------------
   pipelined_riscv_core_mem #(.WORDS(DMEM_WORDS)) Data_Memory (
      .clk_i(clk_i), .we_i(ex_mem_q.mem_write),
      .addr_i(ex_mem_q.alu_result[DAW+1:2]), .wdata_i(ex_mem_q.store_data),
      .rdata_o(dmem_rdata)
   );

   always_comb begin
      mem_wb_d.reg_write  = ex_mem_q.reg_write;
      mem_wb_d.mem_to_reg = ex_mem_q.mem_to_reg;
      mem_wb_d.alu_result = ex_mem_q.alu_result;
      mem_wb_d.mem_data   = dmem_rdata;
      mem_wb_d.rd         = ex_mem_q.rd;
   end

   pipelined_riscv_core_pipe_reg #(.WIDTH($bits(mem_wb_t))) MEMWBRegisters (
      .clk_i(clk_i), .rst_i(rst_i), .en_i(1'b1), .clr_i(1'b0),
      .d_i(mem_wb_d), .q_o(mem_wb_q)
   );

   // ---------------- WB ----------------
   assign wb_data = mem_wb_q.mem_to_reg ? mem_wb_q.mem_data : mem_wb_q.alu_result;

endmodule
`default_nettype wire

// File: tb/tb_pipelined_riscv_core.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_pipelined_riscv_core : directed program checks for pipelined_riscv_core
// Revision : 1.0
// ----------------------------------------------------------------------------
module tb_pipelined_riscv_core;

   logic clk_i = 1'b0;
   logic rst_i;
   logic start_i;

   int vectors     = 0;
   int miscompares = 0;
   int stalls      = 0;
   int flushes     = 0;
   int branches    = 0;

   pipelined_riscv_core dut (
      .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i)
   );

   always #5 clk_i = ~clk_i;

   function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [4:0] rd);
      return {f7, rs2, rs1, f3, rd, 7'b0110011};
   endfunction

   function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd,
                                         input logic [6:0] op);
      return {imm, rs1, f3, rd, op};
   endfunction

   function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                         input logic [4:0] rs1);
      return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
   endfunction

   function automatic logic [31:0] enc_b(input logic [12:0] off, input logic [4:0] rs2,
                                         input logic [4:0] rs1);
      return {off[12], off[10:5], rs2, rs1, 3'b000, off[4:1], off[11], 7'b1100011};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst_i   = 1'b0;
      start_i = 1'b0;
      for (int i = 0; i < 256; i++) dut.Instruction_Memory.memory[i] = 32'h0;
      for (int i = 0; i < 32; i++) begin
         dut.Data_Memory.memory[i]  = 32'h0;
         dut.Registers.register[i]  = 32'h0;
      end
      dut.Registers.register[31] = 32'd123;

      // Reset state and NOP streaming
      #12;
      check("reset_pc", dut.PC.pc_o, 32'd0);
      check("reset_stall", {31'd0, dut.HazardDetectionUnit.Stall_o}, 32'd0);
      check("reset_flush", {31'd0, dut.Flush}, 32'd0);
      @(negedge clk_i) rst_i = 1'b1;
      repeat (2) @(posedge clk_i);
      #1 check("hold_pc_start_low", dut.PC.pc_o, 32'd0);
      @(negedge clk_i) start_i = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         @(posedge clk_i); #1;
         check("nop_pc", dut.PC.pc_o, 32'(4 * k));
         check("nop_stall", {31'd0, dut.HazardDetectionUnit.Stall_o}, 32'd0);
         check("nop_flush", {31'd0, dut.Flush}, 32'd0);
      end
      check("nop_x31_kept", dut.Registers.register[31], 32'd123);
      check("nop_x1_kept", dut.Registers.register[1], 32'd0);

      // Asynchronous reset away from a clock edge, then load the main program
      @(negedge clk_i);
      rst_i   = 1'b0;
      start_i = 1'b0;
      #1 check("async_reset_pc", dut.PC.pc_o, 32'd0);
      dut.Instruction_Memory.memory[0]  = enc_r(7'h00, 5'd29, 5'd28, 3'b000, 5'd1);
      dut.Instruction_Memory.memory[1]  = enc_r(7'h20, 5'd28, 5'd1, 3'b000, 5'd2);
      dut.Instruction_Memory.memory[2]  = enc_i(12'd0, 5'd0, 3'b010, 5'd3, 7'b0000011);
      dut.Instruction_Memory.memory[3]  = enc_r(7'h00, 5'd3, 5'd3, 3'b000, 5'd4);
      dut.Instruction_Memory.memory[4]  = enc_r(7'h01, 5'd25, 5'd24, 3'b000, 5'd5);
      dut.Instruction_Memory.memory[5]  = enc_i(12'h402, 5'd24, 3'b101, 5'd6, 7'b0010011);
      dut.Instruction_Memory.memory[6]  = enc_s(12'd20, 5'd30, 5'd0);
      dut.Instruction_Memory.memory[7]  = enc_i(12'd20, 5'd0, 3'b010, 5'd7, 7'b0000011);
      dut.Instruction_Memory.memory[8]  = enc_b(13'd8, 5'd0, 5'd0);
      dut.Instruction_Memory.memory[9]  = enc_i(12'd1, 5'd0, 3'b000, 5'd8, 7'b0010011);
      dut.Instruction_Memory.memory[10] = enc_b(13'd8, 5'd2, 5'd1);
      dut.Instruction_Memory.memory[11] = enc_i(12'd7, 5'd0, 3'b000, 5'd9, 7'b0010011);
      dut.Registers.register[28] = 32'd56;
      dut.Registers.register[29] = 32'd58;
      dut.Registers.register[24] = -32'd24;
      dut.Registers.register[25] = -32'd25;
      dut.Registers.register[30] = 32'd60;
      dut.Data_Memory.memory[0]  = 32'd5;
      @(negedge clk_i);
      rst_i   = 1'b1;
      start_i = 1'b1;

      for (int c = 1; c <= 24; c++) begin
         @(posedge clk_i); #1;
         if (dut.HazardDetectionUnit.Stall_o) stalls++;
         if (dut.Flush) flushes++;
         if (dut.Control.Branch_o) branches++;
         if (c == 4) begin
            check("x1_not_yet_visible", dut.Registers.register[1], 32'd0);
            check("loaduse_stall_seen", {31'd0, dut.HazardDetectionUnit.Stall_o}, 32'd1);
            check("pc_before_stall", dut.PC.pc_o, 32'd16);
         end
         if (c == 5) begin
            check("x1_visible_5_cycles", dut.Registers.register[1], 32'd114);
            check("pc_held_by_stall", dut.PC.pc_o, 32'd16);
         end
         if (c == 10) begin
            check("beq_taken_flush", {31'd0, dut.Flush}, 32'd1);
            check("pc_at_beq", dut.PC.pc_o, 32'd36);
         end
         if (c == 11) check("pc_branch_target", dut.PC.pc_o, 32'h28);
         if (c == 12) check("beq_not_taken_flush", {31'd0, dut.Flush}, 32'd0);
      end

      check("add_x1", dut.Registers.register[1], 32'd114);
      check("sub_x2_fwd", dut.Registers.register[2], 32'd58);
      check("lw_x3", dut.Registers.register[3], 32'd5);
      check("add_x4_loaduse", dut.Registers.register[4], 32'd10);
      check("mul_x5", dut.Registers.register[5], 32'd600);
      check("srai_x6", dut.Registers.register[6], 32'hFFFF_FFFA);
      check("sw_mem_0x14", dut.Data_Memory.memory[5], 32'd60);
      check("lw_x7", dut.Registers.register[7], 32'd60);
      check("flushed_x8", dut.Registers.register[8], 32'd0);
      check("after_branch_x9", dut.Registers.register[9], 32'd7);
      check("stall_cycles", 32'(stalls), 32'd1);
      check("flush_cycles", 32'(flushes), 32'd1);
      check("branch_decodes", 32'(branches), 32'd2);

      // Reset mid-run discards in-flight work; committed state persists
      @(negedge clk_i);
      rst_i   = 1'b0;
      start_i = 1'b0;
      for (int i = 0; i < 16; i++) dut.Instruction_Memory.memory[i] = 32'h0;
      dut.Instruction_Memory.memory[1] = enc_i(12'd5, 5'd0, 3'b000, 5'd10, 7'b0010011);
      dut.Instruction_Memory.memory[2] = enc_i(12'd6, 5'd0, 3'b000, 5'd11, 7'b0010011);
      dut.Registers.register[10] = 32'd0;
      dut.Registers.register[11] = 32'd0;
      @(negedge clk_i);
      rst_i   = 1'b1;
      start_i = 1'b1;
      repeat (3) @(posedge clk_i);
      #2;
      rst_i   = 1'b0;
      start_i = 1'b0;
      #1 check("midrun_reset_pc", dut.PC.pc_o, 32'd0);
      @(negedge clk_i) rst_i = 1'b1;
      repeat (6) @(posedge clk_i);
      #1;
      check("start_low_pc_hold", dut.PC.pc_o, 32'd0);
      check("discarded_x10", dut.Registers.register[10], 32'd0);
      check("discarded_x11", dut.Registers.register[11], 32'd0);
      check("persist_x1", dut.Registers.register[1], 32'd114);
      check("persist_mem", dut.Data_Memory.memory[5], 32'd60);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
